// File: rtl/ksort_unit.sv
// Streaming top-K selector: keeps the K smallest unsigned distances seen since
// the last start, sorted ascending, each tagged with its arrival index.
module ksort_unit #(
  parameter int unsigned K = 20,
  localparam int unsigned FW = $clog2(K + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [31:0]         in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic [K-1:0][31:0]  out_ksort,
  output logic [K-1:0][31:0]  out_ksort_index,
  output logic [FW-1:0]       fill,
  output logic                out_valid,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [K-1:0][31:0]   val_q;
  logic [K-1:0][31:0]   idx_q;
  logic [K-1:0]         vld_q;
  logic [FW-1:0]        fill_q;
  logic [31:0]          cnt_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [K-1:0]         le;
  logic [K-1:0]         ins;
  logic [K-1:0][31:0]   val_d;
  logic [K-1:0][31:0]   idx_d;
  logic [K-1:0]         vld_d;
  logic                 drop;
  logic                 accept;

  assign in_ready        = (state_q == StRun) && !start;
  assign accept          = in_valid && in_ready;
  assign out_ksort       = val_q;
  assign out_ksort_index = idx_q;
  assign fill            = fill_q;
  assign out_valid       = out_valid_q;
  assign busy            = busy_q;

  // Occupied slots are contiguous and sorted, so le is a thermometer code and
  // the insert slot is the first position where it drops to zero.
  always_comb begin
    le    = '0;
    ins   = '0;
    val_d = val_q;
    idx_d = idx_q;
    vld_d = vld_q;
    for (int i = 0; i < K; i++) begin
      le[i] = vld_q[i] && (val_q[i] <= in_data);
    end
    ins[0] = !le[0];
    for (int i = 1; i < K; i++) begin
      ins[i] = !le[i] && le[i-1];
    end
    drop = &le;
    if (!le[0]) begin
      val_d[0] = in_data;
      idx_d[0] = cnt_q;
      vld_d[0] = 1'b1;
    end
    for (int i = 1; i < K; i++) begin
      if (le[i]) begin
        val_d[i] = val_q[i];
        idx_d[i] = idx_q[i];
        vld_d[i] = vld_q[i];
      end else if (ins[i]) begin
        val_d[i] = in_data;
        idx_d[i] = cnt_q;
        vld_d[i] = 1'b1;
      end else begin
        val_d[i] = val_q[i-1];
        idx_d[i] = idx_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      val_q       <= '1;
      idx_q       <= '1;
      vld_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (start) begin
      state_q     <= StRun;
      val_q       <= '1;
      idx_q       <= '1;
      vld_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (accept) begin
            cnt_q <= cnt_q + 32'd1;
            if (!drop) begin
              val_q <= val_d;
              idx_q <= idx_d;
              vld_q <= vld_d;
              if (fill_q != FW'(K)) fill_q <= fill_q + FW'(1);
            end
            if (in_last) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        StDone: begin
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
